// File: rtl/fir_tap_scheduler_if.sv
// Host/RAM/MAC signal bundle for the FIR tap scheduler.
interface fir_tap_scheduler_if;
    logic        iEnSample600k;
    logic [5:0]  iNumOfCoeff;
    logic        iWrReq;
    logic [5:0]  iWrAddr;
    logic [15:0] iWrData;
    logic        oWrAck;
    logic        oErrAddr;
    logic [3:0]  oCsnRam;
    logic [3:0]  oWrnRam;
    logic [15:0] oAddrRam;
    logic [15:0] oWrDtRam;
    logic        oEnDelay;
    logic        oClrAcc;
    logic [3:0]  oEnMul;
    logic [3:0]  oEnAcc;
    logic        oOutValid;
    logic        oBusy;
    logic        oOverrun;

    modport master (
        output iEnSample600k, iNumOfCoeff, iWrReq, iWrAddr, iWrData,
        input  oWrAck, oErrAddr, oCsnRam, oWrnRam, oAddrRam, oWrDtRam,
        input  oEnDelay, oClrAcc, oEnMul, oEnAcc, oOutValid, oBusy, oOverrun
    );

    modport slave (
        input  iEnSample600k, iNumOfCoeff, iWrReq, iWrAddr, iWrData,
        output oWrAck, oErrAddr, oCsnRam, oWrnRam, oAddrRam, oWrDtRam,
        output oEnDelay, oClrAcc, oEnMul, oEnAcc, oOutValid, oBusy, oOverrun
    );
endinterface

// File: rtl/fir_tap_scheduler.sv
// Per-sample 15-cycle FIR schedule plus idle-time host coefficient writes.
module fir_tap_scheduler (
    input  logic                 iClk12M,
    input  logic                 iRst,
    fir_tap_scheduler_if.slave   bus
);
    localparam int NUM_BANK      = 4;
    localparam int TAPS_PER_BANK = 10;
    localparam int MAX_TAPS      = NUM_BANK * TAPS_PER_BANK;

    typedef enum logic [2:0] {StIdle, StShift, StRead, StDrain, StDone} t_state;

    t_state      r_state, w_state_d;
    logic [3:0]  r_k, w_k_d;
    logic [5:0]  r_num, w_num_d;
    logic [3:0]  r_csn, w_csn_d;
    logic [3:0]  r_wrn, w_wrn_d;
    logic [15:0] r_addr, w_addr_d;
    logic [15:0] r_wdata, w_wdata_d;
    logic        r_ack, w_ack_d;
    logic        r_err, w_err_d;
    logic        r_en_delay, w_en_delay_d;
    logic        r_clr_acc, w_clr_acc_d;
    logic [3:0]  r_en_mul, w_en_mul_d;
    logic [3:0]  r_en_acc, w_en_acc_d;
    logic        r_valid, w_valid_d;
    logic        r_busy, w_busy_d;
    logic        r_overrun, w_overrun_d;

    logic [1:0]  w_bank;
    logic [5:0]  w_off;
    logic        w_addr_ok;

    // Split a global tap index into bank and local address.
    always_comb begin
        w_addr_ok = (bus.iWrAddr < 6'(MAX_TAPS));
        if (bus.iWrAddr < 6'd10) begin
            w_bank = 2'd0;
            w_off  = bus.iWrAddr;
        end else if (bus.iWrAddr < 6'd20) begin
            w_bank = 2'd1;
            w_off  = bus.iWrAddr - 6'd10;
        end else if (bus.iWrAddr < 6'd30) begin
            w_bank = 2'd2;
            w_off  = bus.iWrAddr - 6'd20;
        end else begin
            w_bank = 2'd3;
            w_off  = bus.iWrAddr - 6'd30;
        end
    end

    // Next state and next registered outputs; outputs track the state they belong to.
    always_comb begin
        w_state_d    = r_state;
        w_k_d        = r_k;
        w_num_d      = r_num;
        w_csn_d      = 4'hF;
        w_wrn_d      = 4'hF;
        w_addr_d     = 16'h0000;
        w_wdata_d    = 16'h0000;
        w_ack_d      = 1'b0;
        w_err_d      = 1'b0;
        w_en_delay_d = 1'b0;
        w_clr_acc_d  = 1'b0;
        w_en_mul_d   = 4'h0;
        w_en_acc_d   = r_en_mul;
        w_valid_d    = 1'b0;
        w_overrun_d  = r_overrun | (bus.iEnSample600k && (r_state != StIdle));
        unique case (r_state)
            StIdle: begin
                if (bus.iEnSample600k) begin
                    w_state_d    = StShift;
                    w_en_delay_d = 1'b1;
                    w_clr_acc_d  = 1'b1;
                end else if (bus.iWrReq && !r_ack) begin
                    w_ack_d = 1'b1;
                    if (w_addr_ok) begin
                        w_csn_d[w_bank]             = 1'b0;
                        w_wrn_d[w_bank]             = 1'b0;
                        w_addr_d[{w_bank, 2'b00} +: 4] = w_off[3:0];
                        w_wdata_d                   = bus.iWrData;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            StShift: begin
                w_num_d   = (bus.iNumOfCoeff > 6'(MAX_TAPS)) ? 6'(MAX_TAPS) : bus.iNumOfCoeff;
                w_state_d = StRead;
                w_k_d     = 4'd0;
                w_csn_d   = 4'h0;
                w_addr_d  = 16'h0000;
            end
            StRead: begin
                // Qualify each MAC by the global tap index being read this cycle.
                for (int b = 0; b < NUM_BANK; b++) begin
                    if ((TAPS_PER_BANK * b + int'(r_k)) < int'(r_num)) begin
                        w_en_mul_d[b] = 1'b1;
                    end
                end
                if (r_k == 4'(TAPS_PER_BANK - 1)) begin
                    w_state_d = StDrain;
                    w_k_d     = 4'd0;
                end else begin
                    w_k_d    = r_k + 4'd1;
                    w_csn_d  = 4'h0;
                    w_addr_d = {4{w_k_d}};
                end
            end
            StDrain: begin
                if (r_k == 4'd1) begin
                    w_state_d = StDone;
                    w_k_d     = 4'd0;
                    w_valid_d = 1'b1;
                end else begin
                    w_k_d = r_k + 4'd1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_k_d     = 4'd0;
            end
        endcase
        w_busy_d = (w_state_d != StIdle);
    end

    // State and output registers; reset aborts any schedule and deselects the RAMs.
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            r_state    <= StIdle;
            r_k        <= 4'd0;
            r_num      <= 6'd0;
            r_csn      <= 4'hF;
            r_wrn      <= 4'hF;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_en_delay <= 1'b0;
            r_clr_acc  <= 1'b0;
            r_en_mul   <= 4'h0;
            r_en_acc   <= 4'h0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_k        <= w_k_d;
            r_num      <= w_num_d;
            r_csn      <= w_csn_d;
            r_wrn      <= w_wrn_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_ack      <= w_ack_d;
            r_err      <= w_err_d;
            r_en_delay <= w_en_delay_d;
            r_clr_acc  <= w_clr_acc_d;
            r_en_mul   <= w_en_mul_d;
            r_en_acc   <= w_en_acc_d;
            r_valid    <= w_valid_d;
            r_busy     <= w_busy_d;
            r_overrun  <= w_overrun_d;
        end
    end

    assign bus.oCsnRam   = r_csn;
    assign bus.oWrnRam   = r_wrn;
    assign bus.oAddrRam  = r_addr;
    assign bus.oWrDtRam  = r_wdata;
    assign bus.oWrAck    = r_ack;
    assign bus.oErrAddr  = r_err;
    assign bus.oEnDelay  = r_en_delay;
    assign bus.oClrAcc   = r_clr_acc;
    assign bus.oEnMul    = r_en_mul;
    assign bus.oEnAcc    = r_en_acc;
    assign bus.oOutValid = r_valid;
    assign bus.oBusy     = r_busy;
    assign bus.oOverrun  = r_overrun;
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Self-checking bench for fir_tap_scheduler: write table, schedule model, random runs.
module tb_fir_tap_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   exp_ovr = 1'b0;

    fir_tap_scheduler_if bus ();

    fir_tap_scheduler dut (
        .iClk12M (clk),
        .iRst    (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic [3:0]  exp_csn;
        logic [15:0] exp_addr;
        logic        exp_err;
    } wr_vec_t;

    wr_vec_t wr_tab [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected per-cycle outputs d cycles after a strobe, from the timing table.
    function automatic logic [37:0] exp_sched(int d, int n);
        logic [3:0]  csn = 4'hF;
        logic [15:0] addr = 16'h0000;
        logic        dly = 1'b0;
        logic [3:0]  mul = 4'h0;
        logic [3:0]  acc = 4'h0;
        logic        vld = 1'b0;
        logic        bsy = 1'b0;
        logic [3:0]  k4;
        if (d == 1) dly = 1'b1;
        if (d >= 2 && d <= 11) begin
            csn  = 4'h0;
            k4   = 4'(d - 2);
            addr = {k4, k4, k4, k4};
        end
        for (int b = 0; b < 4; b++) begin
            if (d >= 3 && d <= 12 && (10 * b + d - 3) < n) mul[b] = 1'b1;
            if (d >= 4 && d <= 13 && (10 * b + d - 4) < n) acc[b] = 1'b1;
        end
        if (d == 14) vld = 1'b1;
        if (d >= 1 && d <= 14) bsy = 1'b1;
        return {csn, 4'hF, addr, dly, dly, mul, acc, vld, bsy, 1'b0, 1'b0};
    endfunction

    function automatic logic [37:0] act_vec();
        return {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oEnDelay, bus.oClrAcc,
                bus.oEnMul, bus.oEnAcc, bus.oOutValid, bus.oBusy, bus.oWrAck, bus.oErrAddr};
    endfunction

    // Address mapping model: bank = addr/10, local = addr%10.
    task automatic model_write(input logic [5:0] addr, output logic [3:0] csn,
                               output logic [15:0] raddr, output logic err);
        int a = int'(addr);
        csn   = 4'hF;
        raddr = 16'h0000;
        err   = 1'b0;
        if (a >= 40) begin
            err = 1'b1;
        end else begin
            csn[a / 10] = 1'b0;
            raddr = 16'(a % 10) << (4 * (a / 10));
        end
    endtask

    // Wait for the ack within [lo,hi] cycles, check the RAM access, then drop the request.
    task automatic wait_ack(int lo, int hi, logic [15:0] data, logic [3:0] e_csn,
                            logic [15:0] e_addr, logic e_err);
        int cnt = 0;
        bit got = 1'b0;
        while (!got && cnt < hi) begin
            tick();
            cnt++;
            if (bus.oWrAck) got = 1'b1;
        end
        check("ack_window", (got && cnt >= lo), 1);
        check("wr_err", bus.oErrAddr, e_err);
        check("wr_csn", bus.oCsnRam, e_csn);
        check("wr_wrn", bus.oWrnRam, e_csn);
        if (!e_err) begin
            check("wr_addr", bus.oAddrRam, e_addr);
            check("wr_data", bus.oWrDtRam, data);
        end
        bus.iWrReq = 1'b0;
        tick();
        check("ack_pulse", {bus.oWrAck, bus.oErrAddr, bus.oCsnRam}, {2'b00, 4'hF});
    endtask

    task automatic do_write(logic [5:0] addr, logic [15:0] data, logic [3:0] e_csn,
                            logic [15:0] e_addr, logic e_err);
        bus.iWrReq  = 1'b1;
        bus.iWrAddr = addr;
        bus.iWrData = data;
        wait_ack(1, 1, data, e_csn, e_addr, e_err);
    endtask

    // Strobe now; optionally a second strobe at offset s2 and a same-cycle write request.
    task automatic run_sample(int n_in, int s2, bit with_req, logic [5:0] waddr,
                              logic [15:0] wdata);
        int n = (n_in > 40) ? 40 : n_in;
        logic [3:0]  e_csn;
        logic [15:0] e_addr;
        logic        e_err;
        bus.iNumOfCoeff   = 6'(n_in);
        bus.iEnSample600k = 1'b1;
        if (with_req) begin
            bus.iWrReq  = 1'b1;
            bus.iWrAddr = waddr;
            bus.iWrData = wdata;
        end
        for (int d = 1; d <= 14; d++) begin
            tick();
            if (s2 >= 0 && d == s2 + 1) exp_ovr = 1'b1;
            check($sformatf("sched_n%0d_d%0d", n_in, d), act_vec(), exp_sched(d, n));
            check("overrun", bus.oOverrun, exp_ovr);
            bus.iEnSample600k = (d == s2);
        end
        if (with_req) begin
            model_write(waddr, e_csn, e_addr, e_err);
            wait_ack(1, 2, wdata, e_csn, e_addr, e_err);
        end else begin
            tick();
            check("sched_idle", act_vec(), exp_sched(15, n));
        end
    endtask

    initial begin
        logic [3:0]  r_csn;
        logic [15:0] r_addr;
        logic        r_err;
        logic [5:0]  ra;
        logic [15:0] rd;
        bit          seen_valid;

        wr_tab[0] = '{6'd0,  16'h1234, 4'hE, 16'h0000, 1'b0};
        wr_tab[1] = '{6'd15, 16'hABCD, 4'hD, 16'h0050, 1'b0};
        wr_tab[2] = '{6'd39, 16'h7FFF, 4'h7, 16'h9000, 1'b0};
        wr_tab[3] = '{6'd45, 16'h5555, 4'hF, 16'h0000, 1'b1};
        wr_tab[4] = '{6'd9,  16'h0001, 4'hE, 16'h0009, 1'b0};
        wr_tab[5] = '{6'd20, 16'hBEEF, 4'hB, 16'h0000, 1'b0};
        wr_tab[6] = '{6'd31, 16'h0F0F, 4'h7, 16'h1000, 1'b0};
        wr_tab[7] = '{6'd40, 16'hFFFF, 4'hF, 16'h0000, 1'b1};
        wr_tab[8] = '{6'd27, 16'h8001, 4'hB, 16'h0700, 1'b0};

        bus.iEnSample600k = 1'b0;
        bus.iNumOfCoeff   = 6'd0;
        bus.iWrReq        = 1'b0;
        bus.iWrAddr       = 6'd0;
        bus.iWrData       = 16'h0000;
        tick();
        tick();
        check("reset_vec", {act_vec(), bus.oWrDtRam, bus.oOverrun},
              {4'hF, 4'hF, 30'h0, 16'h0000, 1'b0});
        rst = 1'b0;
        tick();

        foreach (wr_tab[i]) begin
            do_write(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].exp_csn,
                     wr_tab[i].exp_addr, wr_tab[i].exp_err);
        end

        run_sample(40, -1, 1'b0, 6'd0, 16'h0);
        run_sample(23, -1, 1'b0, 6'd0, 16'h0);
        run_sample(0, -1, 1'b0, 6'd0, 16'h0);
        run_sample(63, -1, 1'b0, 6'd0, 16'h0);
        run_sample(40, -1, 1'b1, 6'd15, 16'hABCD);

        for (int i = 0; i < 12; i++) begin
            ra = 6'($urandom_range(0, 47));
            rd = 16'($urandom);
            run_sample(int'($urandom_range(0, 63)), -1, (i % 4 == 3), ra, rd);
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                ra = 6'($urandom_range(0, 47));
                rd = 16'($urandom);
                model_write(ra, r_csn, r_addr, r_err);
                do_write(ra, rd, r_csn, r_addr, r_err);
            end
            repeat ($urandom_range(0, 4)) tick();
        end

        run_sample(40, 8, 1'b0, 6'd0, 16'h0);
        tick();
        check("overrun_sticky", bus.oOverrun, 1);

        // Abort a schedule mid-READ with reset.
        bus.iNumOfCoeff   = 6'd40;
        bus.iEnSample600k = 1'b1;
        tick();
        bus.iEnSample600k = 1'b0;
        repeat (4) tick();
        check("pre_abort_csn", bus.oCsnRam, 4'h0);
        rst = 1'b1;
        tick();
        exp_ovr = 1'b0;
        check("abort_csn", bus.oCsnRam, 4'hF);
        check("abort_wrn", bus.oWrnRam, 4'hF);
        check("abort_busy", bus.oBusy, 0);
        check("abort_overrun", bus.oOverrun, exp_ovr);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.oOutValid || bus.oBusy) seen_valid = 1'b1;
        end
        check("no_valid_after_abort", seen_valid, 0);

        run_sample(10, -1, 1'b0, 6'd0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
